fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 129 ++++++++++++
 tb/tb_fetch_stage.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: credit-limited imem requester, in-flight address FIFO,
// stale-response filtering after redirects, and a 2-entry instruction queue to ID.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc
);

  // Storage is sized for exactly two entries; pointers are therefore one bit wide.
  localparam logic [2:0] DepthW = 3'(DEPTH);

  logic [31:0] r_pc;

  logic [31:0] r_if_addr [0:1];
  logic        r_if_wr;
  logic        r_if_rd;
  logic [1:0]  r_if_cnt;
  logic [1:0]  r_stale_cnt;

  logic [31:0] r_q_pc   [0:1];
  logic [31:0] r_q_inst [0:1];
  logic        r_q_wr;
  logic        r_q_rd;
  logic [1:0]  r_q_cnt;

  logic [1:0]  w_live_cnt;
  logic [2:0]  w_used;
  logic        w_req_fire;
  logic        w_rsp_pop;
  logic        w_rsp_live;
  logic        w_deq;

  // Credit and handshake decode; stale entries hold only their FIFO slot, not credit.
  always_comb begin
    w_live_cnt     = r_if_cnt - r_stale_cnt;
    w_used         = {1'b0, r_q_cnt} + {1'b0, w_live_cnt};
    imem_req_valid = rst_n && !redirect_valid && (w_used < DepthW)
                     && ({1'b0, r_if_cnt} < DepthW);
    imem_req_addr  = r_pc;
    w_req_fire     = imem_req_valid && imem_req_ready;
    // A response with nothing recorded in flight is ignored.
    w_rsp_pop      = imem_rsp_valid && (r_if_cnt != 2'd0);
    // Stale entries are always the oldest, so a nonzero stale count means the head is stale.
    w_rsp_live     = w_rsp_pop && (r_stale_cnt == 2'd0) && !redirect_valid;
    id_valid       = (r_q_cnt != 2'd0);
    w_deq          = id_valid && id_ready && !redirect_valid;
    id_inst        = id_valid ? r_q_inst[r_q_rd] : 32'h0;
    id_pc          = id_valid ? r_q_pc[r_q_rd] : 32'h0;
  end

  // Fetch PC: redirect wins, otherwise advance on each accepted request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else if (redirect_valid) begin
      r_pc <= {redirect_pc[31:2], 2'b00};
    end else if (w_req_fire) begin
      r_pc <= r_pc + 32'd4;
    end
  end

  // In-flight address FIFO plus count of stale (pre-redirect) entries at its head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_if_addr[0] <= '0;
      r_if_addr[1] <= '0;
      r_if_wr      <= 1'b0;
      r_if_rd      <= 1'b0;
      r_if_cnt     <= 2'd0;
      r_stale_cnt  <= 2'd0;
    end else begin
      if (w_req_fire) begin
        r_if_addr[r_if_wr] <= r_pc;
        r_if_wr            <= ~r_if_wr;
      end
      if (w_rsp_pop) begin
        r_if_rd <= ~r_if_rd;
      end
      r_if_cnt <= r_if_cnt + {1'b0, w_req_fire} - {1'b0, w_rsp_pop};
      if (redirect_valid) begin
        // Everything still outstanding after this cycle's pop belongs to the old path.
        r_stale_cnt <= r_if_cnt - {1'b0, w_rsp_pop};
      end else if (w_rsp_pop && (r_stale_cnt != 2'd0)) begin
        r_stale_cnt <= r_stale_cnt - 2'd1;
      end
    end
  end

  // Instruction queue: live responses enqueue, ID handshake dequeues, redirect flushes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q_pc[0]   <= '0;
      r_q_pc[1]   <= '0;
      r_q_inst[0] <= '0;
      r_q_inst[1] <= '0;
      r_q_wr      <= 1'b0;
      r_q_rd      <= 1'b0;
      r_q_cnt     <= 2'd0;
    end else if (redirect_valid) begin
      r_q_wr  <= 1'b0;
      r_q_rd  <= 1'b0;
      r_q_cnt <= 2'd0;
    end else begin
      if (w_rsp_live) begin
        r_q_pc[r_q_wr]   <= r_if_addr[r_if_rd];
        r_q_inst[r_q_wr] <= imem_rsp_data;
        r_q_wr           <= ~r_q_wr;
      end
      if (w_deq) begin
        r_q_rd <= ~r_q_rd;
      end
      r_q_cnt <= r_q_cnt + {1'b0, w_rsp_live} - {1'b0, w_deq};
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed + randomized bench for fetch_stage with an in-order imem model and a PC scoreboard.
module tb_fetch_stage;

  localparam logic [31:0] ResetPc = 32'h0000_0000;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_inst;
  logic [31:0] id_pc;

  fetch_stage #(
    .RESET_PC (ResetPc),
    .DEPTH    (2)
  ) u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_inst        (id_inst),
    .id_pc          (id_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
    int          ep;
  } mem_t;

  mem_t        mem_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] deq_log[$];
  logic [31:0] model_pc;
  int          arrived;
  int          epoch;
  int          cyc_n;
  int          lat;
  bit          spurious;
  int          n_tests;
  int          n_fail;
  int          n_xfer;
  int          n_deq;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // One clock cycle: check outputs at the falling edge, update models, then drive the memory.
  task automatic cyc();
    bit          xfer;
    bit          deq;
    bit          live_rsp;
    logic        exp_rv;
    @(negedge clk);
    exp_rv = !redirect_valid && (exp_q.size() < 2) && (mem_q.size() < 2);
    chk("req_valid", {31'b0, imem_req_valid}, {31'b0, exp_rv});
    if (imem_req_valid) chk("req_addr", imem_req_addr, model_pc);
    chk("id_valid", {31'b0, id_valid}, {31'b0, arrived > 0});
    if (id_valid && exp_q.size() > 0) begin
      chk("id_pc", id_pc, exp_q[0]);
      chk("id_inst", id_inst, inst_of(exp_q[0]));
    end
    xfer     = imem_req_valid && imem_req_ready;
    deq      = id_valid && id_ready && !redirect_valid;
    live_rsp = imem_rsp_valid && mem_q.size() > 0 && mem_q[0].ep == epoch && !redirect_valid;
    if (imem_rsp_valid && mem_q.size() > 0) void'(mem_q.pop_front());
    if (redirect_valid) begin
      exp_q.delete();
      deq_log.delete();
      arrived  = 0;
      epoch++;
      model_pc = redirect_pc & ~32'h3;
    end else begin
      if (deq && exp_q.size() > 0) begin
        deq_log.push_back(exp_q.pop_front());
        arrived--;
        n_deq++;
      end
      if (live_rsp) arrived++;
      if (xfer) begin
        exp_q.push_back(model_pc);
        model_pc += 32'd4;
      end
    end
    if (xfer) begin
      mem_q.push_back('{imem_req_addr, cyc_n + lat, epoch});
      n_xfer++;
    end
    @(posedge clk);
    #1;
    cyc_n++;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc_n) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = inst_of(mem_q[0].addr);
    end else begin
      imem_rsp_valid = spurious;
      imem_rsp_data  = 32'hDEAD_BEEF;
    end
  endtask

  // Hold reset for n cycles, checking the reset-state outputs each cycle.
  task automatic do_reset(input int n);
    rst_n = 1'b0;
    mem_q.delete();
    exp_q.delete();
    deq_log.delete();
    arrived        = 0;
    epoch++;
    model_pc       = ResetPc;
    imem_rsp_valid = 1'b0;
    repeat (n) begin
      @(negedge clk);
      chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
      chk("rst_id_valid", {31'b0, id_valid}, 32'd0);
      chk("rst_id_inst", id_inst, 32'd0);
      chk("rst_id_pc", id_pc, 32'd0);
      chk("rst_pc", imem_req_addr, ResetPc);
      @(posedge clk);
      #1;
      cyc_n++;
    end
    rst_n = 1'b1;
  endtask

  task automatic redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    cyc();
    redirect_valid = 1'b0;
  endtask

  initial begin
    int base;
    rst_n = 1'b0; imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b0;
    lat = 1; spurious = 1'b0; n_tests = 0; n_fail = 0; n_xfer = 0; n_deq = 0;
    cyc_n = 0; epoch = 0; arrived = 0; model_pc = ResetPc;
    @(posedge clk);
    #1;
    do_reset(2);

    // Stall from the start: only two requests go out; raising id_ready resumes fetch.
    base = n_xfer;
    repeat (8) cyc();
    chk("stall_xfers", n_xfer - base, 32'd2);
    id_ready = 1'b1;
    repeat (20) cyc();
    chk("stream_progress", {31'b0, n_deq >= 10}, 32'd1);

    // Redirect while two requests are in flight.
    lat = 3;
    for (int i = 0; i < 20 && mem_q.size() < 2; i++) cyc();
    chk("redir_setup", mem_q.size(), 32'd2);
    lat = 1;
    redirect(32'h0000_0100);
    repeat (12) cyc();
    chk("redir_n", {31'b0, deq_log.size() >= 2}, 32'd1);
    if (deq_log.size() >= 2) begin
      chk("redir_pc0", deq_log[0], 32'h0000_0100);
      chk("redir_pc1", deq_log[1], 32'h0000_0104);
    end

    // Back-to-back redirects, the second misaligned.
    redirect(32'h0000_0300);
    redirect(32'h0000_0203);
    chk("misalign_addr", imem_req_addr, 32'h0000_0200);
    repeat (8) cyc();
    if (deq_log.size() > 0) chk("misalign_first", deq_log[0], 32'h0000_0200);

    // PC wrap at the top of the address space.
    redirect(32'hFFFF_FFF8);
    repeat (12) cyc();
    chk("wrap_n", {31'b0, deq_log.size() >= 3}, 32'd1);
    if (deq_log.size() >= 3) begin
      chk("wrap_pc0", deq_log[0], 32'hFFFF_FFF8);
      chk("wrap_pc1", deq_log[1], 32'hFFFF_FFFC);
      chk("wrap_pc2", deq_log[2], 32'h0000_0000);
    end

    // Unsolicited response while the queue is full and nothing is in flight.
    id_ready = 1'b0;
    repeat (6) cyc();
    spurious = 1'b1;
    cyc();
    spurious = 1'b0;
    repeat (3) cyc();
    id_ready = 1'b1;
    repeat (10) cyc();

    // Randomized traffic with backpressure, variable latency and occasional redirects.
    base = n_deq;
    for (int i = 0; i < 400; i++) begin
      lat            = int'($urandom_range(1, 3));
      imem_req_ready = ($urandom_range(0, 3) != 0);
      id_ready       = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0) redirect($urandom());
      else cyc();
    end
    chk("rand_progress", {31'b0, (n_deq - base) > 50}, 32'd1);

    // Reset mid-stream with the queue full, then restart from the reset PC.
    imem_req_ready = 1'b1;
    lat            = 1;
    id_ready       = 1'b0;
    repeat (6) cyc();
    chk("full_before_rst", {31'b0, id_valid}, 32'd1);
    do_reset(1);
    id_ready = 1'b1;
    repeat (8) cyc();
    chk("post_rst_n", {31'b0, deq_log.size() >= 1}, 32'd1);
    if (deq_log.size() >= 1) chk("post_rst_pc", deq_log[0], ResetPc);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish before bound");
    $fatal(1, "timeout");
  end

endmodule
